// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: access sizes, controller
// states and the alignment rule used on the request path.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } dmem_state_t;

    // Only the two address LSBs matter for alignment; size 11 is rejected separately.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            MEM_H:   ok = ~lo[0];
            MEM_W:   ok = (lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data memory (slave).
interface dmem_lsu_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, size, uns, addr, wdata,
        input  busy, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, uns, addr, wdata,
        output busy, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_lsu_extend.sv
// Combinational sign/zero extension of a raw little-endian 32-bit read
// according to access size and the unsigned flag.
module lsu_extend
    import riscv_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            MEM_B:   ext = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            MEM_H:   ext = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed little-endian data memory with load/store unit: clears itself
// after reset, checks alignment, and returns extended load data one cycle later.
module dmem_lsu
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input logic         clk,
    input logic         rst,
    dmem_lsu_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [7:0]       mem [DEPTH];
    dmem_state_t      state;
    logic [IDX_W-1:0] ptr;

    logic [IDX_W-1:0] idx, idx1, idx2, idx3;
    logic             legal, store_acc, load_acc, bad_acc;
    logic [31:0]      raw, ext;
    logic             unused_addr;

    assign idx  = bus.addr[IDX_W-1:0];
    assign idx1 = idx + IDX_W'(1);
    assign idx2 = idx + IDX_W'(2);
    assign idx3 = idx + IDX_W'(3);
    assign unused_addr = ^bus.addr[ADDR_W-1:IDX_W];

    assign legal     = (bus.size != 2'b11) && is_aligned(bus.size, bus.addr[1:0]);
    assign store_acc = (state == ST_READY) && bus.req && legal && bus.we;
    assign load_acc  = (state == ST_READY) && bus.req && legal && !bus.we;
    assign bad_acc   = (state == ST_READY) && bus.req && !legal;

    // Wrapped neighbour indices only feed bytes that the extender discards.
    assign raw = {mem[idx3], mem[idx2], mem[idx1], mem[idx]};

    lsu_extend u_extend (
        .raw  (raw),
        .size (bus.size),
        .uns  (bus.uns),
        .ext  (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            bus.busy   <= 1'b1;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.err    <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ptr        <= ptr + IDX_W'(1);
                    bus.rvalid <= 1'b0;
                    if (ptr == LAST) begin
                        state    <= ST_READY;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    bus.rvalid <= load_acc;
                    if (load_acc) bus.rdata <= ext;
                    if (bad_acc)  bus.err   <= 1'b1;
                end
            endcase
        end
    end

    // Byte array: cleared one entry per cycle, then written by accepted stores.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= 8'h00;
            end else if (store_acc) begin
                mem[idx] <= bus.wdata[7:0];
                if (bus.size != MEM_B) mem[idx1] <= bus.wdata[15:8];
                if (bus.size == MEM_W) begin
                    mem[idx2] <= bus.wdata[23:16];
                    mem[idx3] <= bus.wdata[31:24];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed and randomized bench for dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;
    import riscv_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(32)) bus ();

    dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(32)) mem1 (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  mm [DEPTH];
    logic        err_m = 1'b0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem_all(input string tag);
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(mem1.mem[i]), 32'(mm[i]));
    endtask

    // Reset, optionally with a request already on the bus, then wait out the clear
    // while hammering the bus with a store that must be ignored.
    task automatic reset_and_clear(input string tag);
        int n;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, ".busy"},   32'(bus.busy),   32'd1);
        chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'd0);
        chk({tag, ".rdata"},  bus.rdata,       32'd0);
        chk({tag, ".err"},    32'(bus.err),    32'd0);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'hFFFF_FFFF;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.busy && n < DEPTH + 8);
        bus.req = 1'b0;
        chk({tag, ".clear_cycles"}, 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
        err_m = 1'b0;
        last_rd = 32'h0;
        chk_mem_all({tag, ".mem"});
        chk({tag, ".err_after"}, 32'(bus.err), 32'd0);
    endtask

    // One access cycle; the model decides the expected outcome from the rules directly.
    task automatic access(input string tag, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd);
        int          nb;
        logic        exp_v;
        logic [31:0] v;
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u;
        bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        nb = 1 << sz;
        exp_v = 1'b0;
        if (sz == 2'b11 || (a % nb) != 0) begin
            err_m = 1'b1;
        end else if (w) begin
            for (int k = 0; k < nb; k++)
                mm[int'((a + k) % DEPTH)] = 8'(wd >> (8 * k));
        end else begin
            v = 32'h0;
            for (int k = 0; k < nb; k++)
                v = v | (32'(mm[int'((a + k) % DEPTH)]) << (8 * k));
            if (!u && nb < 4 && v[8 * nb - 1])
                v = v | ~((32'd1 << (8 * nb)) - 32'd1);
            exp_v = 1'b1;
            last_rd = v;
        end
        chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'(exp_v));
        chk({tag, ".rdata"},  bus.rdata,       last_rd);
        chk({tag, ".err"},    32'(bus.err),    32'(err_m));
    endtask

    task automatic idle(input string tag);
        bus.req = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'd0);
        chk({tag, ".rdata"},  bus.rdata,       last_rd);
    endtask

    initial begin
        int          r;
        logic [1:0]  sz;
        logic [31:0] a;

        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;

        reset_and_clear("rst0");

        access("sw28", 1'b1, MEM_W, 1'b0, 32'd28, 32'h1122_3344);
        chk("sw28.m28", 32'(mem1.mem[28]), 32'h44);
        chk("sw28.m29", 32'(mem1.mem[29]), 32'h33);
        chk("sw28.m30", 32'(mem1.mem[30]), 32'h22);
        chk("sw28.m31", 32'(mem1.mem[31]), 32'h11);
        access("lw28", 1'b0, MEM_W, 1'b1, 32'd28, 32'h0);
        chk("lw28.const", bus.rdata, 32'h1122_3344);
        idle("idle0");

        access("sb12",  1'b1, MEM_B, 1'b0, 32'd12, 32'h0000_0080);
        access("lb12",  1'b0, MEM_B, 1'b0, 32'd12, 32'h0);
        chk("lb12.const", bus.rdata, 32'hFFFF_FF80);
        access("lbu12", 1'b0, MEM_B, 1'b1, 32'd12, 32'h0);
        chk("lbu12.const", bus.rdata, 32'h0000_0080);
        access("sh16",  1'b1, MEM_H, 1'b0, 32'd16, 32'h0000_8001);
        access("lh16",  1'b0, MEM_H, 1'b0, 32'd16, 32'h0);
        chk("lh16.const", bus.rdata, 32'hFFFF_8001);

        access("sw20", 1'b1, MEM_W, 1'b0, 32'd20, 32'hAABB_CCDD);
        access("sb21", 1'b1, MEM_B, 1'b0, 32'd21, 32'h0000_0005);
        access("lw20", 1'b0, MEM_W, 1'b0, 32'd20, 32'h0);
        chk("lw20.const", bus.rdata, 32'hAABB_05DD);

        access("lw22_mis", 1'b0, MEM_W, 1'b0, 32'd22, 32'h0);
        chk("lw22_mis.errc", 32'(bus.err), 32'd1);
        access("sh13_mis", 1'b1, MEM_H, 1'b0, 32'd13, 32'hDEAD_BEEF);
        for (int i = 12; i < 16; i++)
            chk($sformatf("sh13_mis.m%0d", i), 32'(mem1.mem[i]), 32'(mm[i]));
        access("sz11", 1'b0, 2'b11, 1'b0, 32'd0, 32'h0);
        idle("idle1");
        chk("err_sticky", 32'(bus.err), 32'd1);

        // Random traffic, mostly aligned, covering back-to-back loads and stores.
        for (int t = 0; t < 300; t++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a  = $urandom;
            if ($urandom_range(0, 7) != 0 && sz != 2'b11)
                a = a & ~(32'(1 << sz) - 32'd1);
            if ($urandom_range(0, 9) == 0) idle($sformatf("ridle%0d", t));
            access($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz,
                   1'($urandom_range(0, 1)), a, $urandom);
        end
        idle("idle2");
        chk_mem_all("rnd.mem");

        // Load issued on the same edge as reset must be dropped.
        access("sw28b", 1'b1, MEM_W, 1'b0, 32'd28, 32'h1122_3344);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = MEM_W; bus.uns = 1'b0; bus.addr = 32'd28;
        reset_and_clear("rst_mid");
        access("lw28_post", 1'b0, MEM_W, 1'b0, 32'd28, 32'h0);
        chk("lw28_post.const", bus.rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
